lieat_general_skidbuf: RTL and testbench

LIEAT_GENERAL_SKIDBUF -- requirements
Module: lieat_general_skidbuf

---
 rtl/lieat_general_skidbuf.sv | 96 +++++++++
 tb/tb_lieat_general_skidbuf.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/lieat_general_skidbuf.sv
// Two-entry skid buffer: registered valid/ready on both sides, full throughput, in-order.
// Optional synchronous flush port enabled by defining LIEAT_SKIDBUF_FLUSH_EN.
module lieat_general_skidbuf #(
    parameter int unsigned DW      = 32,
    parameter logic [31:0] DEFAULT = 32'h00000000
) (
    input  logic          clk,
    input  logic          rstn,
`ifdef LIEAT_SKIDBUF_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data
);

    localparam logic [DW-1:0] RstVal = DW'(DEFAULT);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          main_vld_q, main_vld_d;
    logic          skid_vld_q, skid_vld_d;
    logic          push, pop;

    assign push = i_valid & i_ready;
    assign pop  = o_valid & o_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    main_d  = i_data;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_d = i_data;
                end else if (push) begin
                    state_d = StFull;
                    skid_d  = i_data;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // i_ready is low here, so only a pop can move the state
                if (pop) begin
                    state_d = StOne;
                    main_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
`ifdef LIEAT_SKIDBUF_FLUSH_EN
        // Flush drops the beats but leaves the data registers untouched
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
`endif
        main_vld_d = (state_d != StEmpty);
        skid_vld_d = (state_d == StFull);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StEmpty;
            main_q     <= RstVal;
            skid_q     <= RstVal;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign o_valid = main_vld_q;
    assign o_data  = main_q;
    assign i_ready = ~skid_vld_q;

endmodule

// File: tb/tb_lieat_general_skidbuf.sv
// Scoreboard bench for lieat_general_skidbuf; flush tests built when LIEAT_SKIDBUF_FLUSH_EN is defined.
module tb_lieat_general_skidbuf;

    localparam logic [31:0] Def = 32'h80000000;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_data;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;

    int          n_tests;
    int          n_fail;
    logic [31:0] sb[$];
    logic        stall_v;
    logic [31:0] stall_data;

    lieat_general_skidbuf #(
        .DW      (32),
        .DEFAULT (Def)
    ) u_dut (
        .clk     (clk),
        .rstn    (rstn),
`ifdef LIEAT_SKIDBUF_FLUSH_EN
        .flush   (flush),
`endif
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs with the model, then advance the model and the clock by one cycle.
    task automatic step();
        check_eq("o_valid", {31'd0, o_valid}, {31'd0, sb.size() > 0});
        check_eq("i_ready", {31'd0, i_ready}, {31'd0, sb.size() < 2});
        if (o_valid && sb.size() > 0) check_eq("o_data", o_data, sb[0]);
        if (stall_v) check_eq("stall_hold", o_data, stall_data);
        if (flush) begin
            sb.delete();
            stall_v = 1'b0;
        end else begin
            if (o_valid && o_ready && sb.size() > 0) void'(sb.pop_front());
            if (i_valid && i_ready) sb.push_back(i_data);
            stall_v    = o_valid && !o_ready;
            stall_data = o_data;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check_eq("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_i_ready", {31'd0, i_ready}, 32'd1);
        check_eq("rst_o_data", o_data, Def);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        sb.delete();
        stall_v = 1'b0;
        check_eq("post_rst_o_data", o_data, Def);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        o_ready = r;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        stall_v = 1'b0;
        flush   = 1'b0;
        rstn    = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        do_reset();
        step();

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        step();

        // Backpressure into FULL, then a pop while C is offered
        drive(1'b1, 32'hA, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0);
        step();
        check_eq("full_i_ready", {31'd0, i_ready}, 32'd0);
        check_eq("full_o_data", o_data, 32'hA);
        drive(1'b1, 32'hC, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check_eq("fullpop_o_data", o_data, 32'hB);
        check_eq("fullpop_i_ready", {31'd0, i_ready}, 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_eq("drained_o_valid", {31'd0, o_valid}, 32'd0);
        step();

`ifdef LIEAT_SKIDBUF_FLUSH_EN
        drive(1'b1, 32'h11, 1'b0);
        step();
        drive(1'b1, 32'h12, 1'b0);
        step();
        drive(1'b1, 32'hD, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check_eq("flush_o_valid", {31'd0, o_valid}, 32'd0);
        check_eq("flush_i_ready", {31'd0, i_ready}, 32'd1);
        check_eq("flush_keeps_data", o_data, 32'h11);
        step();
        step();
`endif

        // Random traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
`ifdef LIEAT_SKIDBUF_FLUSH_EN
                flush = ($urandom_range(0, 39) == 0);
`endif
                step();
                flush = 1'b0;
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
